// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract-shift
// for divide. Multiply keeps the multiplier in lo_in and shifts product bits
// into it from the top; divide keeps the dividend/quotient in lo_in and
// shifts quotient bits in from the bottom.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             mult,
  input  logic [WIDTH:0]   hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Single iteration of either algorithm, selected by mult.
  always_comb begin
    sum     = hi_in + (lo_in[0] ? {1'b0, opnd} : '0);
    shifted = {hi_in[WIDTH-1:0], lo_in[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    hi_out  = '0;
    lo_out  = '0;
    if (mult) begin
      hi_out = {1'b0, sum[WIDTH:1]};
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end else if (!diff[WIDTH+1]) begin
      hi_out = diff[WIDTH:0];
      lo_out = {lo_in[WIDTH-2:0], 1'b1};
    end else begin
      hi_out = shifted;
      lo_out = {lo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Signed operations run on magnitudes; signs are re-applied in FIX.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write hi/lo directly
// RUN   | one radix-2 step per cycle, ITER steps
// FIX   | sign correction, hi/lo written, done pulsed on exit
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MDU_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER) + 1;

  mdu_state_t state, state_nxt;
  logic             accept;
  logic [WIDTH:0]   acc_hi, step_hi;
  logic [WIDTH-1:0] acc_lo, step_lo, opnd;
  logic             is_mult, neg_res, neg_rem, div_zero;
  logic [CW-1:0]    cnt;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .mult   (is_mult),
    .hi_in  (acc_hi),
    .lo_in  (acc_lo),
    .opnd   (opnd),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  // Operand magnitudes; op[0]=0 selects the signed variants.
  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Sign-corrected results; a zero divisor leaves the all-ones quotient as is.
  always_comb begin
    prod     = {acc_hi[WIDTH-1:0], acc_lo};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = (neg_res && !div_zero) ? -acc_lo : acc_lo;
    rem_fix  = neg_rem ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !op[2]) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CW'(ITER - 1)) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath, architectural HI/LO and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_mult  <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == FIX);
      if (accept) begin
        acc_hi   <= '0;
        acc_lo   <= op[1] ? a_mag : b_mag;
        opnd     <= op[1] ? b_mag : a_mag;
        is_mult  <= ~op[1];
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        div_zero <= (b == '0);
        cnt      <= '0;
      end else if (state == RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt + 1'b1;
      end
      if (state == FIX) begin
        if (is_mult) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end else if (state == IDLE && start) begin
        if (op == OP_MTHI) hi <= a;
        if (op == OP_MTLO) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO pushed at issue,
// popped and compared by a monitor whenever done is seen.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic        prev_done = 1'b0;

  mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic, returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      3'd0: ref_model = 64'(sx * sy);
      3'd1: ref_model = ux * uy;
      default: begin
        if (y == 32'h0) ref_model = {x, 32'hFFFF_FFFF};
        else if (o == 3'd2) begin
          q = sx / sy;
          r = sx % sy;
          ref_model = {r[31:0], q[31:0]};
        end else begin
          ref_model = {32'(ux % uy), 32'(ux / uy)};
        end
      end
    endcase
  endfunction

  // Monitor: compare result on every done pulse.
  always @(negedge clk) begin
    if (done) begin
      chk("done_busy_excl", {63'h0, busy}, 64'h0);
      chk("done_one_cycle", {63'h0, prev_done}, 64'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        chk("result_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
    prev_done <= done;
  end

  // Issue one op from a negedge; returns at a negedge with the unit idle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int inject, input int abort_at);
    int count;
    int n;
    bit stable;
    logic [63:0] expv;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    expv  = ref_model(o, av, bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    if (!o[2]) exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    if (!o[2]) begin
      count  = 0;
      stable = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!busy) break;
        count++;
        if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
        a = $urandom;
        b = $urandom;
        if (count == inject) begin
          start = 1'b1;
          op    = 3'd3;
        end else begin
          start = 1'b0;
        end
        if (count == abort_at) begin
          #2 rst_n = 1'b0;
          #1;
          chk("abort_state", {hi, lo, 30'h0, busy, done}, 96'h0);
          exp_q.delete();
          m_hi = 32'h0;
          m_lo = 32'h0;
          @(negedge clk);
          rst_n = 1'b1;
          repeat (3) begin
            @(negedge clk);
            chk("abort_idle", {busy, done, hi, lo}, 66'h0);
          end
          return;
        end
      end
      start = 1'b0;
      chk("latency", 64'(count), 64'd33);
      chk("hold_during_run", {63'h0, stable}, 64'h1);
      chk("done_at_busy_fall", {63'h0, done}, 64'h1);
      m_hi = expv[63:32];
      m_lo = expv[31:0];
    end else begin
      @(negedge clk);
      if (o == 3'd4) m_hi = av;
      if (o == 3'd5) m_lo = av;
      chk("idle_op", {busy, done, hi, lo}, {2'b00, m_hi, m_lo});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] av, bv;
    int sel;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'h0;
    b     = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset", {busy, done, hi, lo}, 66'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_release", {busy, done, hi, lo}, 66'h0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, -1, -1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, -1, -1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1);
    run_op(3'd3, 32'h0000_0007, 32'h0000_0000, -1, -1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, -1, -1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(3'd0, 32'h8000_0000, 32'h7FFF_FFFF, 5, -1);
    run_op(3'd4, 32'h1234_5678, 32'h0, -1, -1);
    run_op(3'd5, 32'hCAFE_F00D, 32'h0, -1, -1);
    run_op(3'd6, 32'hDEAD_BEEF, 32'h1, -1, -1);
    run_op(3'd0, 32'h0000_1234, 32'h0000_5678, -1, 10);
    run_op(3'd0, 32'hFFFF_FF00, 32'h0000_0100, -1, -1);

    for (int k = 0; k < 40; k++) begin
      o   = 3'($urandom_range(0, 7));
      av  = $urandom;
      bv  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) bv = 32'h0;
      if (sel == 1) begin
        av = 32'h8000_0000;
        bv = 32'hFFFF_FFFF;
      end
      if (sel == 2) bv = 32'($urandom_range(1, 15));
      run_op(o, av, bv, -1, -1);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
